// File: rtl/dcache_ctrl_burst_pkg.sv
// dcache_pkg
//   Shared definitions for the write-back dcache control FSM:
//   - state_t    : controller states
//   - HITCT_ADDR : memory word address where the hit counter is stored at halt
//   - cnt_w()    : counter width helper, max(1, clog2(n))
package dcache_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WB      = 3'd1,
      FILL    = 3'd2,
      FSCAN   = 3'd3,
      FWB     = 3'd4,
      CTSTORE = 3'd5,
      HALT    = 3'd6
   } state_t;

   localparam logic [31:0] HITCT_ADDR = 32'h0000_3100;

   // A width of zero is never legal for a port, so a single-word block or a
   // single-frame cache still gets a 1-bit index that simply stays at 0.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dcache_ctrl_burst_blk_word_ctr.sv
// blk_word_ctr
//   Beat counter for one block burst. Counts 0..BLKWORDS-1 and wraps back to
//   0 on the advance that completes the last beat, so every burst starts at
//   word 0 without an explicit clear.
// Ports
//   CLK, nRST : clock, asynchronous active-low reset
//   i_clr     : force count to 0
//   i_adv     : a beat completed this cycle
//   o_cnt     : current word offset
//   o_last    : current beat is the last word of the block
module blk_word_ctr #(
   parameter int BLKWORDS = 2,
   parameter int W        = 1
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         i_clr,
   input  logic         i_adv,
   output logic [W-1:0] o_cnt,
   output logic         o_last
);

   localparam logic [W-1:0] LAST = W'(BLKWORDS - 1);

   logic [W-1:0] r_cnt;

   assign o_cnt  = r_cnt;
   assign o_last = (r_cnt == LAST);

   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_adv) begin
         r_cnt <= o_last ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/dcache_ctrl_burst.sv
// dcache_ctrl_burst
//   Control FSM of the write-back data cache. Services misses as a dirty-victim
//   write-back burst followed by a fill burst, performs the halt-time flush
//   scan over every {set,way} frame, stores the hit counter and parks in HALT.
// Ports
//   CLK, nRST     : clock, asynchronous active-low reset
//   dmemREN/WEN   : datapath read/write request
//   flush         : datapath halt/flush request (level)
//   dhit          : tag match for the current request
//   victim_dirty  : LRU victim of the current set is valid+dirty
//   frame_dirty   : frame at frame_idx is valid+dirty
//   dwait         : memory busy
//   dREN/dWEN     : memory read/write strobe
//   word_off      : word within block for the current beat
//   frame_idx     : frame under flush scan ({set,way})
//   fill_we       : write the returned memory word into the cache
//   tag_update    : pulse, install new tag (valid=1, dirty=0)
//   dirty_clr     : pulse, clear dirty bit of frame_idx
//   hitct_sel     : memory address/data select the hit counter slot
//   hit_count     : current hit count
//   flushing      : flush scan in progress
//   halt          : flush complete, sticky until reset
//   o_dbg_state   : current FSM state
//
// Memory handshake: a strobe (dREN or dWEN) is held asserted for the whole
// beat; the beat completes on the first cycle where the strobe is high and
// dwait is low. While dwait is high, state, word_off and frame_idx hold.
module dcache_ctrl_burst
   import dcache_pkg::*;
#(
   parameter  int BLKWORDS = 2,
   parameter  int SETS     = 8,
   parameter  int WAYS     = 2,
   parameter  int HITCTW   = 32,
   localparam int WOFF_W   = cnt_w(BLKWORDS),
   localparam int FIDX_W   = cnt_w(SETS * WAYS)
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              dmemREN,
   input  logic              dmemWEN,
   input  logic              flush,
   input  logic              dhit,
   input  logic              victim_dirty,
   input  logic              frame_dirty,
   input  logic              dwait,
   output logic              dREN,
   output logic              dWEN,
   output logic [WOFF_W-1:0] word_off,
   output logic [FIDX_W-1:0] frame_idx,
   output logic              fill_we,
   output logic              tag_update,
   output logic              dirty_clr,
   output logic              hitct_sel,
   output logic [HITCTW-1:0] hit_count,
   output logic              flushing,
   output logic              halt,
   output logic [2:0]        o_dbg_state
);

   localparam logic [FIDX_W-1:0] FIDX_LAST = FIDX_W'(SETS * WAYS - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [FIDX_W-1:0]   r_frame_idx;
   logic [HITCTW-1:0]   r_hit_count;

   logic                w_req;
   logic                w_miss;
   logic                w_hit;
   logic                w_ctr_clr;
   logic                w_ctr_adv;
   logic                w_last;
   logic [WOFF_W-1:0]   w_word_off;

   assign w_req  = dmemREN | dmemWEN;
   assign w_miss = w_req & ~dhit;
   assign w_hit  = w_req & dhit;

   assign word_off    = w_word_off;
   assign frame_idx   = r_frame_idx;
   assign hit_count   = r_hit_count;
   assign o_dbg_state = r_state;

   // Holding the counter clear while idle guarantees every burst starts at
   // word 0 even if a previous burst was abandoned.
   assign w_ctr_clr = (r_state == IDLE);

   blk_word_ctr #(
      .BLKWORDS (BLKWORDS),
      .W        (WOFF_W)
   ) u_blk_word_ctr (
      .CLK    (CLK),
      .nRST   (nRST),
      .i_clr  (w_ctr_clr),
      .i_adv  (w_ctr_adv),
      .o_cnt  (w_word_off),
      .o_last (w_last)
   );

   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      dREN        = 1'b0;
      dWEN        = 1'b0;
      fill_we     = 1'b0;
      tag_update  = 1'b0;
      dirty_clr   = 1'b0;
      hitct_sel   = 1'b0;
      flushing    = 1'b0;
      halt        = 1'b0;
      w_ctr_adv   = 1'b0;
      case (r_state)
         IDLE: begin
            // A pending miss is serviced before a flush is honoured.
            if (w_miss) begin
               w_state_nxt = victim_dirty ? WB : FILL;
            end else if (flush) begin
               w_state_nxt = FSCAN;
            end
         end
         WB: begin
            dWEN      = 1'b1;
            w_ctr_adv = ~dwait;
            if (!dwait && w_last) begin
               w_state_nxt = FILL;
            end
         end
         FILL: begin
            dREN      = 1'b1;
            fill_we   = ~dwait;
            w_ctr_adv = ~dwait;
            if (!dwait && w_last) begin
               tag_update  = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         FSCAN: begin
            flushing = 1'b1;
            if (frame_dirty) begin
               w_state_nxt = FWB;
            end else if (r_frame_idx == FIDX_LAST) begin
               w_state_nxt = CTSTORE;
            end
         end
         FWB: begin
            // Return to FSCAN on the same frame; the re-check sees it clean
            // and the scan advances on the following cycle.
            flushing  = 1'b1;
            dWEN      = 1'b1;
            w_ctr_adv = ~dwait;
            if (!dwait && w_last) begin
               dirty_clr   = 1'b1;
               w_state_nxt = FSCAN;
            end
         end
         CTSTORE: begin
            dWEN      = 1'b1;
            hitct_sel = 1'b1;
            if (!dwait) begin
               w_state_nxt = HALT;
            end
         end
         HALT: begin
            halt = 1'b1;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Flush scan pointer: advances only past clean frames, wraps to 0 when
   // the scan hands over to the counter store.
   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         r_frame_idx <= '0;
      end else if (r_state == FSCAN && !frame_dirty) begin
         r_frame_idx <= (r_frame_idx == FIDX_LAST) ? '0 : r_frame_idx + 1'b1;
      end
   end

   // Hits are counted in IDLE only. A miss is charged -1 on entry because
   // the retry after the fill is counted as a hit, so a miss nets zero.
   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         r_hit_count <= '0;
      end else if (r_state == IDLE) begin
         if (w_hit) begin
            r_hit_count <= r_hit_count + 1'b1;
         end else if (w_miss) begin
            r_hit_count <= r_hit_count - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dcache_ctrl_burst.sv
module tb_dcache_ctrl_burst;

  localparam int BLKWORDS = 4;
  localparam int SETS     = 8;
  localparam int WAYS     = 2;
  localparam int HITCTW   = 32;
  localparam int NFRAMES  = SETS * WAYS;
  localparam int REC_W    = 44;

  logic        CLK;
  logic        nRST;
  logic        dmemREN, dmemWEN, flush, dhit, victim_dirty, frame_dirty, dwait;
  logic        dREN, dWEN, fill_we, tag_update, dirty_clr, hitct_sel, flushing, halt;
  logic [1:0]  word_off;
  logic [3:0]  frame_idx;
  logic [31:0] hit_count;
  logic [2:0]  dbg_state;

  logic [REC_W-1:0] exp_q[$];
  int               checks;
  int               errors;
  logic [31:0]      m_hits;
  logic [NFRAMES-1:0] dp_dirty;
  bit               dwait_rand;

  dcache_ctrl_burst #(
    .BLKWORDS (BLKWORDS),
    .SETS     (SETS),
    .WAYS     (WAYS),
    .HITCTW   (HITCTW)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .dmemREN      (dmemREN),
    .dmemWEN      (dmemWEN),
    .flush        (flush),
    .dhit         (dhit),
    .victim_dirty (victim_dirty),
    .frame_dirty  (frame_dirty),
    .dwait        (dwait),
    .dREN         (dREN),
    .dWEN         (dWEN),
    .word_off     (word_off),
    .frame_idx    (frame_idx),
    .fill_we      (fill_we),
    .tag_update   (tag_update),
    .dirty_clr    (dirty_clr),
    .hitct_sel    (hitct_sel),
    .hit_count    (hit_count),
    .flushing     (flushing),
    .halt         (halt),
    .o_dbg_state  (dbg_state)
  );

  // datapath model: dirty bits of every frame, looked up by the scan pointer
  assign frame_dirty = dp_dirty[frame_idx];

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // memory model: random busy cycles, updated just after each rising edge
  initial begin
    dwait = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      dwait = dwait_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- helpers ----------------
  function automatic logic [REC_W-1:0] mk_rec(logic wr, logic [1:0] wo, logic [3:0] fi,
                                              logic tu, logic dc, logic hs, logic fw,
                                              logic fl, logic [31:0] hc);
    return {wr, wo, fi, tu, dc, hs, fw, fl, hc};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [REC_W-1:0] act;
    logic [REC_W-1:0] exp;
    logic             stray;
    forever begin
      @(negedge CLK);
      if (nRST) begin
        stray = (dREN & dWEN) |
                ((tag_update | dirty_clr | fill_we) & (dwait | ~(dREN | dWEN)));
        checks++;
        if (stray) begin
          errors++;
          $display("FAIL stray_pulse: dREN=%b dWEN=%b dwait=%b tu=%b dc=%b fw=%b at %0t",
                   dREN, dWEN, dwait, tag_update, dirty_clr, fill_we, $time);
        end
        if ((dREN | dWEN) && !dwait) begin
          act = mk_rec(dWEN, word_off, frame_idx, tag_update, dirty_clr, hitct_sel,
                       fill_we, flushing, hit_count);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got %0h expected none at %0t", act, $time);
          end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
              errors++;
              $display("FAIL beat: got %0h expected %0h at %0t", act, exp, $time);
            end
          end
          if (dirty_clr) dp_dirty[frame_idx] = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input logic wr, input logic hit, input logic vd);
    dmemREN      = ~wr;
    dmemWEN      = wr;
    dhit         = hit;
    victim_dirty = vd;
  endtask

  task automatic clear_req();
    dmemREN      = 1'b0;
    dmemWEN      = 1'b0;
    dhit         = 1'b0;
    victim_dirty = 1'b0;
  endtask

  task automatic wait_drain(input int limit, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge CLK);
      n++;
    end
    check({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic do_hits(input logic wr, input int n);
    @(posedge CLK);
    #1 set_req(wr, 1'b1, 1'b0);
    repeat (n) @(posedge CLK);
    #1 clear_req();
    m_hits += 32'(n);
  endtask

  // miss: optional victim write-back, then the fill; hit count seen during
  // the burst is one below the model because the retry is still to come
  task automatic start_miss(input logic wr, input logic vd);
    logic [31:0] hc;
    hc = m_hits - 32'd1;
    @(posedge CLK);
    #1 set_req(wr, 1'b0, vd);
    if (vd)
      for (int w = 0; w < BLKWORDS; w++)
        exp_q.push_back(mk_rec(1'b1, 2'(w), 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, hc));
    for (int w = 0; w < BLKWORDS; w++)
      exp_q.push_back(mk_rec(1'b0, 2'(w), 4'd0, (w == BLKWORDS - 1), 1'b0, 1'b0,
                             1'b1, 1'b0, hc));
  endtask

  task automatic finish_miss();
    wait_drain(400, "miss");
    #1 dhit = 1'b1;
    @(posedge CLK);
    #1 clear_req();
  endtask

  task automatic do_miss(input logic wr, input logic vd);
    start_miss(wr, vd);
    finish_miss();
  endtask

  task automatic push_flush(input logic [NFRAMES-1:0] dirty);
    for (int f = 0; f < NFRAMES; f++)
      if (dirty[f])
        for (int w = 0; w < BLKWORDS; w++)
          exp_q.push_back(mk_rec(1'b1, 2'(w), 4'(f), 1'b0, (w == BLKWORDS - 1), 1'b0,
                                 1'b0, 1'b1, m_hits));
    exp_q.push_back(mk_rec(1'b1, 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, m_hits));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_strobes"}, {dREN, dWEN, fill_we, tag_update, dirty_clr, hitct_sel,
                               flushing, halt}, 64'd0);
    check({name, "_word_off"}, word_off, 64'd0);
    check({name, "_frame_idx"}, frame_idx, 64'd0);
    check({name, "_hit_count"}, hit_count, 64'd0);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int n;
    int k;
    logic wr;
    logic [NFRAMES-1:0] scan_dirty;

    checks     = 0;
    errors     = 0;
    m_hits     = 32'd0;
    dp_dirty   = '0;
    dwait_rand = 1'b1;
    flush      = 1'b0;
    clear_req();
    nRST = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge CLK);
    nRST = 1'b1;

    // directed: clean read miss, then dirty write miss
    do_miss(1'b0, 1'b0);
    check("clean_miss_hitct", hit_count, m_hits);
    do_miss(1'b1, 1'b1);
    check("dirty_miss_hitct", hit_count, m_hits);

    // random mix of hits, clean misses and dirty misses
    for (int t = 0; t < 40; t++) begin
      k  = $urandom_range(0, 2);
      wr = 1'($urandom_range(0, 1));
      if (k == 0) do_hits(wr, $urandom_range(1, 4));
      else        do_miss(wr, (k == 2));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge CLK);
    end
    check("random_hitct", hit_count, m_hits);

    // miss and flush raised together; frames 3 and 12 dirty
    scan_dirty = '0;
    scan_dirty[3]  = 1'b1;
    scan_dirty[12] = 1'b1;
    dp_dirty = scan_dirty;
    start_miss(1'b0, 1'b1);
    flush = 1'b1;
    check("miss_before_flush", flushing, 64'd0);
    finish_miss();
    push_flush(scan_dirty);
    wait_drain(800, "flush");
    #1;
    check("halt_set", halt, 64'd1);
    check("dirty_left", dp_dirty, 64'd0);
    for (int c = 0; c < 100; c++) begin
      @(posedge CLK);
      #1 set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge CLK);
      check("halt_hold", {halt, dREN, dWEN}, 64'b100);
    end
    clear_req();
    check("halt_hitct", hit_count, m_hits);

    // reset while the second fill beat is in progress
    @(posedge CLK);
    #1 nRST = 1'b0;
    flush  = 1'b0;
    m_hits = 32'd0;
    @(posedge CLK);
    #1 nRST = 1'b1;
    check("post_reset_halt", halt, 64'd0);
    start_miss(1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(dREN && word_off == 2'd1) && n < 200);
    check("reach_fill_beat2", n < 200, 64'd1);
    #1 nRST = 1'b0;
    exp_q.delete();
    clear_req();
    #1;
    check_reset_outputs("midfill_reset");
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;
    check_reset_outputs("midfill_release");

    // 10 hits and 3 misses, then a flush with nothing dirty
    dwait_rand = 1'b0;
    dp_dirty   = '0;
    for (int i = 0; i < 13; i++) begin
      wr = 1'($urandom_range(0, 1));
      if (i == 2 || i == 6 || i == 10) do_miss(wr, 1'($urandom_range(0, 1)));
      else                             do_hits(wr, 1);
    end
    check("ten_hits", hit_count, 64'd10);
    push_flush('0);
    @(posedge CLK);
    #1 flush = 1'b1;
    n = 0;
    do begin
      @(posedge CLK);
      n++;
      #1;
    end while (!halt && n < 100);
    check("clean_flush_latency", n, 64'(NFRAMES + 2));
    wait_drain(50, "final");
    check("final_hitct", hit_count, 64'd10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
